// File: rtl/hazard_seq_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Optional feature macro: HAZARD_PERF_CNT_EN (enables stall/flush counters).
package hazard_seq_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  localparam int STATE_W       = 2;
  localparam int CNT_W_DEFAULT = 32;
  localparam int STALL_CTR_W   = 4;
  localparam int WAIT_CTR_W    = 16;

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
// Only compiled when HAZARD_PERF_CNT_EN is defined, so the default build
// carries no counter logic at all.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count one per enabled cycle, wrapping naturally at 2^W
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// jump/bne/jr redirects and data-memory wait freezes.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall_cnt/flush_cnt counters;
// when undefined both ports are tied to zero).
module pipeline_hazard_sequencer
  import hazard_seq_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int WAIT_TIMEOUT      = 255,
  parameter int CNT_W             = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jump,
  input  logic               bne,
  input  logic               jr,
  input  logic               id_ex_memread,
  input  logic [4:0]         id_ex_rt,
  input  logic [4:0]         if_id_rs,
  input  logic [4:0]         if_id_rt,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               pipe_hold,
  output logic               if_flush,
  output logic               id_flush,
  output logic [STATE_W-1:0] state_o,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [STALL_CTR_W-1:0] STALL_RELOAD = STALL_CTR_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [WAIT_CTR_W-1:0]  TIMEOUT_VAL  = WAIT_CTR_W'(WAIT_TIMEOUT);

  hazard_state_t          state;
  hazard_state_t          state_next;
  logic [STALL_CTR_W-1:0] stall_ctr;
  logic [STALL_CTR_W-1:0] stall_ctr_next;
  logic [WAIT_CTR_W-1:0]  wait_ctr;
  logic                   hazard;
  logic                   redirect;
  logic                   resume_stall;

  assign hazard = id_ex_memread && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign redirect = jump | bne | jr;

  // A pending bubble count survives a memory wait; the cycle memory becomes
  // ready is treated as the resumed state so no extra dead cycle is added.
  assign resume_stall = (state == STALL) ||
                        ((state == MEM_WAIT) && (stall_ctr != '0));

  assign state_o = state;

  // Next-state and control outputs; memory wait beats load-use beats redirect
  always_comb begin
    state_next     = state;
    stall_ctr_next = stall_ctr;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    pipe_hold      = 1'b0;
    if_flush       = 1'b0;
    id_flush       = 1'b0;

    if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      state_next  = MEM_WAIT;
    end else if (resume_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_flush    = 1'b1;
      if (stall_ctr <= STALL_CTR_W'(1)) begin
        state_next     = RUN;
        stall_ctr_next = '0;
      end else begin
        state_next     = STALL;
        stall_ctr_next = stall_ctr - STALL_CTR_W'(1);
      end
    end else if (hazard) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      id_flush       = 1'b1;
      stall_ctr_next = STALL_RELOAD;
      state_next     = (LOAD_STALL_CYCLES == 1) ? RUN : STALL;
    end else if (redirect) begin
      if_flush   = 1'b1;
      id_flush   = bne | jr;
      state_next = RUN;
    end else begin
      state_next = RUN;
    end

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
    end
  end

  // State, bubble counter and memory-wait watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_ctr   <= '0;
      wait_ctr    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      stall_ctr <= stall_ctr_next;
      if (mem_busy) begin
        if (state != MEM_WAIT) begin
          wait_ctr <= WAIT_CTR_W'(1);
        end else begin
          if (wait_ctr == TIMEOUT_VAL) begin
            err_timeout <= 1'b1;
          end
          if (wait_ctr != '1) begin
            wait_ctr <= wait_ctr + WAIT_CTR_W'(1);
          end
        end
      end else begin
        wait_ctr <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // A bubble is an ID flush without a fetch flush; redirects always flush IF
  hazard_perf_counter #(.W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .en    (id_flush & ~if_flush),
    .count (stall_cnt)
  );

  hazard_perf_counter #(.W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .en    (if_flush & ~reset),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer: directed scenarios
// followed by randomized traffic, all compared to a cycle-level model.
module tb_pipeline_hazard_sequencer;

  localparam int L_STALL = 2;
  localparam int T_OUT   = 4;
  localparam int CW      = 32;

  logic clk = 1'b0;
  logic reset, jump, bne, jr, id_ex_memread, mem_busy;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic pc_write, if_id_write, pipe_hold, if_flush, id_flush, err_timeout;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding bubbles, consecutive busy cycles, sticky error
  int pending_bubbles = 0;
  int busy_run = 0;
  bit prev_busy = 1'b0;
  bit m_err = 1'b0;
  bit model_valid = 1'b0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .LOAD_STALL_CYCLES (L_STALL),
    .WAIT_TIMEOUT      (T_OUT),
    .CNT_W             (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .jump          (jump),
    .bne           (bne),
    .jr            (jr),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .mem_busy      (mem_busy),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .pipe_hold     (pipe_hold),
    .if_flush      (if_flush),
    .id_flush      (id_flush),
    .state_o       (state_o),
    .err_timeout   (err_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check the current cycle at the falling edge, then advance the model
  task automatic modelCycle();
    bit hz, bub;
    logic e_pc, e_ifid, e_hold, e_iff, e_idf;
    logic [1:0] e_state;
    @(negedge clk);
    hz = id_ex_memread && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    bub = 1'b0;
    if (reset) begin
      {e_pc, e_ifid, e_hold, e_iff, e_idf} = 5'b00011;
    end else if (mem_busy) begin
      {e_pc, e_ifid, e_hold, e_iff, e_idf} = 5'b00100;
    end else if (pending_bubbles > 0 || hz) begin
      {e_pc, e_ifid, e_hold, e_iff, e_idf} = 5'b00001;
      bub = 1'b1;
    end else if (jump || bne || jr) begin
      {e_pc, e_ifid, e_hold, e_iff, e_idf} = {4'b1101, bne | jr};
    end else begin
      {e_pc, e_ifid, e_hold, e_iff, e_idf} = 5'b11000;
    end
    e_state = prev_busy ? 2'd2 : ((pending_bubbles > 0) ? 2'd1 : 2'd0);

    checkOutput("pc_write", 32'(pc_write), 32'(e_pc));
    checkOutput("if_id_write", 32'(if_id_write), 32'(e_ifid));
    checkOutput("pipe_hold", 32'(pipe_hold), 32'(e_hold));
    checkOutput("if_flush", 32'(if_flush), 32'(e_iff));
    checkOutput("id_flush", 32'(id_flush), 32'(e_idf));
    if (model_valid) begin
      checkOutput("state_o", 32'(state_o), 32'(e_state));
      checkOutput("err_timeout", 32'(err_timeout), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
      checkOutput("stall_cnt", stall_cnt, m_stall);
      checkOutput("flush_cnt", flush_cnt, m_flush);
`else
      checkOutput("stall_cnt", stall_cnt, 32'd0);
      checkOutput("flush_cnt", flush_cnt, 32'd0);
`endif
    end

    if (reset) begin
      pending_bubbles = 0;
      busy_run = 0;
      prev_busy = 1'b0;
      m_err = 1'b0;
      m_stall = '0;
      m_flush = '0;
      model_valid = 1'b1;
    end else begin
      if (mem_busy) begin
        busy_run++;
        if (busy_run == T_OUT + 1) m_err = 1'b1;
        prev_busy = 1'b1;
      end else begin
        busy_run = 0;
        prev_busy = 1'b0;
        if (pending_bubbles > 0) pending_bubbles--;
        else if (hz) pending_bubbles = L_STALL - 1;
      end
      if (bub) m_stall = m_stall + 1;
      if (e_iff) m_flush = m_flush + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and check it
  task automatic applyStimulus(input logic rst, input logic j, input logic b,
                               input logic r, input logic mr,
                               input logic [4:0] exrt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic busy);
    reset = rst; jump = j; bne = b; jr = r;
    id_ex_memread = mr; id_ex_rt = exrt; if_id_rs = rs; if_id_rt = rt;
    mem_busy = busy;
    modelCycle();
  endtask

  initial begin
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd3; regs[2] = 5'd5; regs[3] = 5'd9;

    // Reset held two cycles, then release into RUN
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0);

    // Load-use on rs: two bubble cycles, then back to normal fetch
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 5, 5, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 5, 1, 0);

    // Register zero never hazards; jump flushes IF only, jr flushes both
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Hazard on rt alongside bne: bubbles first, held bne acted on afterwards
    repeat (2) applyStimulus(0, 0, 1, 0, 1, 7, 2, 7, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 2, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2, 7, 0);

    // Memory wait in the middle of a stall; stall resumes afterwards
    applyStimulus(0, 0, 0, 0, 1, 4, 4, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 0);

    // Long memory wait trips the sticky timeout, cleared only by reset
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with clustered memory waits and rare resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) == 0),
                    regs[$urandom_range(0, 3)],
                    regs[$urandom_range(0, 3)],
                    regs[$urandom_range(0, 3)],
                    (mem_busy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
